// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command front end: data widths, opcode map
// and the sequencer state encoding.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 4;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [OP_W-1:0]   op_t;

    localparam op_t OP_ADD    = 4'h0;
    localparam op_t OP_SUB    = 4'h1;
    localparam op_t OP_MUL    = 4'h2;
    localparam op_t OP_DIV    = 4'h3;
    localparam op_t OP_SHL    = 4'h4;
    localparam op_t OP_SHR    = 4'h5;
    localparam op_t OP_ROL    = 4'h6;
    localparam op_t OP_ROR    = 4'h7;
    localparam op_t OP_AND    = 4'h8;
    localparam op_t OP_XOR    = 4'h9;
    localparam op_t OP_CMP_GT = 4'hA;
    localparam op_t OP_CMP_EQ = 4'hB;
    localparam op_t OP_OR     = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_CAPT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and result handshake bundle between control logic and the sequencer.
interface alu_cmd_sequencer_if #(parameter int REG_AW = 2);

    logic                       cmd_valid;
    logic                       cmd_ready;
    logic                       cmd_load;
    logic [alu_pkg::OP_W-1:0]   cmd_op;
    logic [REG_AW-1:0]          cmd_src_a;
    logic [REG_AW-1:0]          cmd_src_b;
    logic [REG_AW-1:0]          cmd_dst;
    logic [alu_pkg::DATA_W-1:0] cmd_imm;

    logic                       res_valid;
    logic                       res_ready;
    logic [alu_pkg::DATA_W-1:0] res_data;
    logic [REG_AW-1:0]          res_dst;

    modport master (
        output cmd_valid, cmd_load, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, cmd_imm,
        input  cmd_ready,
        input  res_valid, res_data, res_dst,
        output res_ready
    );

    modport slave (
        input  cmd_valid, cmd_load, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, cmd_imm,
        output cmd_ready,
        output res_valid, res_data, res_dst,
        input  res_ready
    );

endinterface

// File: rtl/alu_regfile.sv
// Operand/result register file: one write port, two operand read ports and a
// debug read port, all reads combinational.
module alu_regfile
    import alu_pkg::*;
#(
    parameter  int NUM_REGS = 4,
    localparam int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  data_t             wr_data,
    input  logic [REG_AW-1:0] rd_addr_a,
    output data_t             rd_data_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output data_t             rd_data_b,
    input  logic [REG_AW-1:0] rd_addr_dbg,
    output data_t             rd_data_dbg
);

    data_t regs [NUM_REGS];

    // NOTE: this array is reset on purpose -- every entry is architecturally
    // visible as 0x00 after reset, so it must be flops, not an inferred RAM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a   = regs[rd_addr_a];
    assign rd_data_b   = regs[rd_addr_b];
    assign rd_data_dbg = regs[rd_addr_dbg];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Serialises load/ALU commands: reads operands, drives the registered ALU,
// writes the result back and offers it on the result handshake.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter  int NUM_REGS = 4,
    localparam int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    alu_cmd_sequencer_if.slave cmd_bus,
    output data_t             alu_in_a,
    output data_t             alu_in_b,
    output op_t               alu_op_code,
    input  data_t             alu_result,
    input  logic [REG_AW-1:0] dbg_addr,
    output data_t             dbg_data
);

    state_t            state;
    logic [REG_AW-1:0] dst_q;
    logic              res_valid_q;
    data_t             res_data_q;
    logic [REG_AW-1:0] res_dst_q;
    data_t             opnd_a;
    data_t             opnd_b;
    logic              wr_en;
    logic [REG_AW-1:0] wr_addr;
    data_t             wr_data;

    // Loads write at the accept edge; ALU results write when leaving CAPT.
    assign wr_en   = ((state == ST_IDLE) && cmd_bus.cmd_valid && cmd_bus.cmd_load) ||
                     (state == ST_CAPT);
    assign wr_addr = (state == ST_IDLE) ? cmd_bus.cmd_dst : dst_q;
    assign wr_data = (state == ST_IDLE) ? cmd_bus.cmd_imm : alu_result;

    alu_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr_a   (cmd_bus.cmd_src_a),
        .rd_data_a   (opnd_a),
        .rd_addr_b   (cmd_bus.cmd_src_b),
        .rd_data_b   (opnd_b),
        .rd_addr_dbg (dbg_addr),
        .rd_data_dbg (dbg_data)
    );

    // NOTE: all state below uses non-blocking assignments so every branch sees
    // pre-edge values, which is what makes SRC == DST read the old register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            dst_q       <= '0;
            alu_in_a    <= '0;
            alu_in_b    <= '0;
            alu_op_code <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_dst_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_bus.cmd_valid) begin
                        if (cmd_bus.cmd_load) begin
                            res_data_q  <= cmd_bus.cmd_imm;
                            res_dst_q   <= cmd_bus.cmd_dst;
                            res_valid_q <= 1'b1;
                            state       <= ST_RESP;
                        end else begin
                            alu_in_a    <= opnd_a;
                            alu_in_b    <= opnd_b;
                            alu_op_code <= cmd_bus.cmd_op;
                            dst_q       <= cmd_bus.cmd_dst;
                            state       <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: state <= ST_CAPT;
                ST_CAPT: begin
                    res_data_q  <= alu_result;
                    res_dst_q   <= dst_q;
                    res_valid_q <= 1'b1;
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (cmd_bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Ready is masked by reset so nothing upstream sees a stale IDLE.
    assign cmd_bus.cmd_ready = (state == ST_IDLE) && reset_n;
    assign cmd_bus.res_valid = res_valid_q;
    assign cmd_bus.res_data  = res_data_q;
    assign cmd_bus.res_dst   = res_dst_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural ALU and a
// register-file reference model driven by directed and random commands.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int NUM_REGS = 4;
    localparam int REG_AW   = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    data_t             alu_in_a, alu_in_b, alu_result;
    op_t               alu_op_code;
    logic [REG_AW-1:0] dbg_addr;
    data_t             dbg_data;

    alu_cmd_sequencer_if #(.REG_AW(REG_AW)) bus ();

    alu_cmd_sequencer #(.NUM_REGS(NUM_REGS)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_bus     (bus),
        .alu_in_a    (alu_in_a),
        .alu_in_b    (alu_in_b),
        .alu_op_code (alu_op_code),
        .alu_result  (alu_result),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    function automatic data_t alu_fn(data_t a, data_t b, op_t op);
        data_t r;
        case (op)
            OP_ADD:    r = a + b;
            OP_SUB:    r = a - b;
            OP_MUL:    r = a * b;
            OP_DIV:    r = (b == 0) ? 8'h00 : a / b;
            OP_SHL:    r = a << 1;
            OP_SHR:    r = a >> 1;
            OP_ROL:    r = {a[6:0], a[7]};
            OP_ROR:    r = {a[0], a[7:1]};
            OP_AND:    r = a & b;
            OP_XOR:    r = a ^ b;
            OP_CMP_GT: r = (a > b) ? 8'h01 : 8'h00;
            OP_CMP_EQ: r = (a == b) ? 8'h01 : 8'h00;
            OP_OR:     r = a | b;
            4'hD:      r = ~(a | b);
            4'hE:      r = ~(a & b);
            default:   r = ~(a ^ b);
        endcase
        return r;
    endfunction

    // One-cycle registered ALU sitting behind the sequencer.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) alu_result <= '0;
        else          alu_result <= alu_fn(alu_in_a, alu_in_b, alu_op_code);
    end

    int    checks = 0;
    int    errors = 0;
    data_t ref_rf [NUM_REGS];
    data_t last_a, last_b;
    op_t   last_op;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) ref_rf[i] = 8'h00;
        last_a  = 8'h00;
        last_b  = 8'h00;
        last_op = 4'h0;
    endtask

    task automatic set_cmd(input bit load, input op_t op, input logic [REG_AW-1:0] sa,
                           input logic [REG_AW-1:0] sb, input logic [REG_AW-1:0] dst,
                           input data_t imm);
        bus.cmd_load  = load;
        bus.cmd_op    = op;
        bus.cmd_src_a = sa;
        bus.cmd_src_b = sb;
        bus.cmd_dst   = dst;
        bus.cmd_imm   = imm;
    endtask

    task automatic check_dbg(input string tag, input logic [REG_AW-1:0] idx, input data_t exp);
        dbg_addr = idx;
        #1;
        check(tag, dbg_data, exp);
    endtask

    // Issue one command, follow it to the handshake and compare against the model.
    task automatic run_cmd(input bit load, input op_t op, input logic [REG_AW-1:0] sa,
                           input logic [REG_AW-1:0] sb, input logic [REG_AW-1:0] dst,
                           input data_t imm, input int hold);
        data_t a_exp, b_exp, d_exp;
        op_t   op_exp;
        int    lat, n;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin step(); n++; end
        check("cmd_ready_before_accept", bus.cmd_ready, 1);
        a_exp  = load ? last_a  : ref_rf[sa];
        b_exp  = load ? last_b  : ref_rf[sb];
        op_exp = load ? last_op : op;
        d_exp  = load ? imm : alu_fn(ref_rf[sa], ref_rf[sb], op);
        set_cmd(load, op, sa, sb, dst, imm);
        bus.cmd_valid = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (!bus.res_valid && lat < 10) begin step(); lat++; end
        check(load ? "load_latency" : "alu_latency", lat, load ? 1 : 3);
        check("res_data", bus.res_data, d_exp);
        check("res_dst", bus.res_dst, dst);
        check("alu_in_a", alu_in_a, a_exp);
        check("alu_in_b", alu_in_b, b_exp);
        check("alu_op_code", alu_op_code, op_exp);
        last_a = a_exp; last_b = b_exp; last_op = op_exp;
        ref_rf[dst] = d_exp;
        if (hold > 0) begin
            bus.res_ready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                step();
                check("hold_res_valid", bus.res_valid, 1);
                check("hold_res_data", bus.res_data, d_exp);
                check("hold_cmd_ready", bus.cmd_ready, 0);
            end
        end
        bus.res_ready = 1'b1;
        step();
        check("res_valid_after_hs", bus.res_valid, 0);
        check("cmd_ready_after_hs", bus.cmd_ready, 1);
        check_dbg("dbg_after_write", dst, d_exp);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        set_cmd(1'b0, 4'h0, 2'd0, 2'd0, 2'd0, 8'h00);
        dbg_addr = '0;
        model_reset();

        // Reset behaviour.
        #12;
        check("cmd_ready_in_reset", bus.cmd_ready, 0);
        check("res_valid_in_reset", bus.res_valid, 0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check("cmd_ready_after_reset", bus.cmd_ready, 1);
        check("res_valid_after_reset", bus.res_valid, 0);
        for (int i = 0; i < NUM_REGS; i++) check_dbg("dbg_reset", REG_AW'(i), 8'h00);

        // ADD r2 = r0 + r1.
        run_cmd(1'b1, 4'h0, 2'd0, 2'd0, 2'd0, 8'h05, 0);
        run_cmd(1'b1, 4'h0, 2'd0, 2'd0, 2'd1, 8'h03, 0);
        run_cmd(1'b0, OP_ADD, 2'd0, 2'd1, 2'd2, 8'h00, 0);
        check_dbg("add_r2", 2'd2, 8'h08);

        // Truncating MUL, SRC==DST subtraction, wrap-around subtraction; one held response.
        run_cmd(1'b1, 4'h0, 2'd0, 2'd0, 2'd0, 8'h10, 0);
        run_cmd(1'b1, 4'h0, 2'd0, 2'd0, 2'd1, 8'h10, 0);
        run_cmd(1'b0, OP_MUL, 2'd0, 2'd1, 2'd3, 8'h00, 5);
        check_dbg("mul_r3", 2'd3, 8'h00);
        run_cmd(1'b0, OP_SUB, 2'd1, 2'd0, 2'd0, 8'h00, 0);
        check_dbg("sub_r0_zero", 2'd0, 8'h00);
        run_cmd(1'b0, OP_SUB, 2'd0, 2'd1, 2'd0, 8'h00, 0);
        check_dbg("sub_r0_wrap", 2'd0, 8'hF0);

        // Reset during EXEC of ADD r2 aborts everything.
        run_cmd(1'b1, 4'h0, 2'd0, 2'd0, 2'd0, 8'h05, 0);
        run_cmd(1'b1, 4'h0, 2'd0, 2'd0, 2'd1, 8'h03, 0);
        set_cmd(1'b0, OP_ADD, 2'd0, 2'd1, 2'd2, 8'h00);
        bus.cmd_valid = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("cmd_ready_mid_reset", bus.cmd_ready, 0);
        check("res_valid_mid_reset", bus.res_valid, 0);
        #20;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            check("res_valid_after_abort", bus.res_valid, 0);
        end
        check("cmd_ready_after_abort", bus.cmd_ready, 1);
        check_dbg("abort_r2", 2'd2, 8'h00);

        // Back-to-back: valid held high across two loads, second waits for handshake.
        bus.res_ready = 1'b0;
        set_cmd(1'b1, 4'h0, 2'd0, 2'd0, 2'd0, 8'h07);
        bus.cmd_valid = 1'b1;
        step();
        set_cmd(1'b1, 4'h0, 2'd0, 2'd0, 2'd1, 8'h03);
        for (int i = 0; i < 3; i++) begin
            check("b2b_first_data", bus.res_data, 8'h07);
            check("b2b_first_dst", bus.res_dst, 0);
            check("b2b_not_ready", bus.cmd_ready, 0);
            step();
        end
        bus.res_ready = 1'b1;
        step();
        check("b2b_ready_again", bus.cmd_ready, 1);
        check("b2b_valid_low", bus.res_valid, 0);
        step();
        bus.cmd_valid = 1'b0;
        check("b2b_second_valid", bus.res_valid, 1);
        check("b2b_second_data", bus.res_data, 8'h03);
        check("b2b_second_dst", bus.res_dst, 1);
        ref_rf[0] = 8'h07;
        ref_rf[1] = 8'h03;
        step();
        run_cmd(1'b0, OP_CMP_GT, 2'd0, 2'd1, 2'd2, 8'h00, 0);
        check_dbg("cmp_gt_r2", 2'd2, 8'h01);

        // Random command mix against the reference model.
        for (int k = 0; k < 60; k++) begin
            run_cmd(bit'($urandom_range(0, 2) == 0),
                    op_t'($urandom_range(0, 15)),
                    REG_AW'($urandom_range(0, NUM_REGS - 1)),
                    REG_AW'($urandom_range(0, NUM_REGS - 1)),
                    REG_AW'($urandom_range(0, NUM_REGS - 1)),
                    data_t'($urandom_range(0, 255)),
                    int'($urandom_range(0, 3)));
        end
        for (int i = 0; i < NUM_REGS; i++) check_dbg("final_rf", REG_AW'(i), ref_rf[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
